// File: rtl/adpcm_pcm_arbiter_pkg.sv
// Shared encodings for the ADPCM-A/ADPCM-B PCM memory and mux arbiter.
// Includes the mux bus field layout and the idle pin values.
package adpcm_pcm_arbiter_pkg;

    localparam int ADDR_W    = 24;
    localparam int DATA_W    = 8;
    localparam int COUNT_W   = 8;
    localparam int MUX_BUS_W = 10;

    // Mux bus layout: {pcm_load, ym_io_en, ym_io_out[3:0], mux_oe_n, mux_sel[2:0]}
    localparam int MUX_SEL_LSB   = 0;
    localparam int MUX_SEL_W     = 3;
    localparam int MUX_OE_N_BIT  = 3;
    localparam int YM_IO_OUT_LSB = 4;
    localparam int YM_IO_OUT_W   = 4;
    localparam int YM_IO_EN_BIT  = 8;
    localparam int PCM_LOAD_BIT  = 9;

    localparam logic [MUX_BUS_W-1:0] MUX_BUS_IDLE = 10'h008;
    localparam logic [COUNT_W-1:0]   COUNT_MAX    = 8'hFF;

    typedef enum logic [1:0] {
        MEM_IDLE    = 2'd0,
        MEM_GRANT_A = 2'd1,
        MEM_GRANT_B = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_A    = 2'd1,
        OWNER_B    = 2'd2
    } mux_owner_t;

    typedef enum logic {
        SIDE_A = 1'b0,
        SIDE_B = 1'b1
    } side_t;

    function automatic logic pick_b(input logic a_req, input logic b_req,
                                    input logic rr_is_b, input logic round_robin);
        return b_req && (!a_req || !round_robin || rr_is_b);
    endfunction

endpackage

// File: rtl/adpcm_pcm_arbiter_pcm_mux_owner.sv
// Tracks which ADPCM reader owns the PCM mux pins and forwards its bus.
// Also counts cycles in which a reader needed the mux but was refused.
module pcm_mux_owner
    import adpcm_pcm_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 a_mux_needed,
    input  logic [MUX_BUS_W-1:0] a_mux_bus,
    input  logic                 b_mux_needed,
    input  logic [MUX_BUS_W-1:0] b_mux_bus,
    input  logic                 stat_clear,
    output logic [MUX_BUS_W-1:0] mux_bus,
    output logic [COUNT_W-1:0]   conflict_count
);

    mux_owner_t owner_q;
    mux_owner_t grant;
    logic       denied;

    // The current owner keeps the mux while it still needs it; otherwise B has priority.
    always_comb begin
        grant = OWNER_NONE;
        if (!reset_n) begin
            grant = OWNER_NONE;
        end else if (owner_q == OWNER_A && a_mux_needed) begin
            grant = OWNER_A;
        end else if (owner_q == OWNER_B && b_mux_needed) begin
            grant = OWNER_B;
        end else if (b_mux_needed) begin
            grant = OWNER_B;
        end else if (a_mux_needed) begin
            grant = OWNER_A;
        end
    end

    always_comb begin
        denied = (a_mux_needed && grant != OWNER_A) ||
                 (b_mux_needed && grant != OWNER_B);
    end

    always_comb begin
        mux_bus = MUX_BUS_IDLE;
        case (grant)
            OWNER_A: mux_bus = a_mux_bus;
            OWNER_B: mux_bus = b_mux_bus;
            default: mux_bus = MUX_BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q        <= OWNER_NONE;
            conflict_count <= '0;
        end else begin
            owner_q <= grant;
            if (stat_clear) begin
                conflict_count <= '0;
            end else if (denied && conflict_count != COUNT_MAX) begin
                conflict_count <= conflict_count + 8'd1;
            end
        end
    end

endmodule

// File: rtl/adpcm_pcm_arbiter.sv
// Shares one PCM memory read port and the PCM mux/YM IO pins between ADPCM-A and ADPCM-B.
// The memory arbiter lives here; mux ownership is delegated to pcm_mux_owner.
module adpcm_pcm_arbiter
    import adpcm_pcm_arbiter_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 a_mem_valid,
    input  logic [ADDR_W-1:0]    a_mem_addr,
    output logic                 a_mem_ready,
    output logic [DATA_W-1:0]    a_mem_rdata,
    input  logic                 b_mem_valid,
    input  logic [ADDR_W-1:0]    b_mem_addr,
    output logic                 b_mem_ready,
    output logic [DATA_W-1:0]    b_mem_rdata,
    output logic                 mem_valid,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic                 mem_ready,
    input  logic [DATA_W-1:0]    mem_rdata,
    input  logic                 a_mux_needed,
    input  logic [MUX_BUS_W-1:0] a_mux_bus,
    input  logic                 b_mux_needed,
    input  logic [MUX_BUS_W-1:0] b_mux_bus,
    output logic [2:0]           mux_sel,
    output logic                 mux_oe_n,
    output logic [3:0]           ym_io_out,
    output logic                 ym_io_en,
    output logic                 pcm_load,
    output logic [COUNT_W-1:0]   conflict_count,
    input  logic                 stat_clear
);

    localparam logic RR_EN = (ROUND_ROBIN != 0);

    mem_state_t            state_q;
    mem_state_t            state_d;
    side_t                 rr_q;
    side_t                 rr_d;
    logic [DATA_W-1:0]     a_rdata_q;
    logic [DATA_W-1:0]     b_rdata_q;
    logic                  winner_b;
    logic                  mem_valid_c;
    logic [ADDR_W-1:0]     mem_addr_c;
    logic                  a_ready_c;
    logic                  b_ready_c;
    logic [MUX_BUS_W-1:0]  mux_bus;

    always_comb begin
        winner_b = pick_b(a_mem_valid, b_mem_valid, rr_q == SIDE_B, RR_EN);
    end

    // IDLE forwards the winner with no added latency; a grant ends on mem_ready or
    // when the grantee withdraws, and either way passes through IDLE before the next grant.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        mem_valid_c = 1'b0;
        mem_addr_c  = '0;
        a_ready_c   = 1'b0;
        b_ready_c   = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (a_mem_valid || b_mem_valid) begin
                    mem_valid_c = 1'b1;
                    if (winner_b) begin
                        mem_addr_c = b_mem_addr;
                        state_d    = MEM_GRANT_B;
                    end else begin
                        mem_addr_c = a_mem_addr;
                        state_d    = MEM_GRANT_A;
                    end
                end
            end
            MEM_GRANT_A: begin
                if (!a_mem_valid) begin
                    state_d = MEM_IDLE;
                end else begin
                    mem_valid_c = 1'b1;
                    mem_addr_c  = a_mem_addr;
                    if (mem_ready) begin
                        a_ready_c = 1'b1;
                        state_d   = MEM_IDLE;
                        rr_d      = SIDE_B;
                    end
                end
            end
            MEM_GRANT_B: begin
                if (!b_mem_valid) begin
                    state_d = MEM_IDLE;
                end else begin
                    mem_valid_c = 1'b1;
                    mem_addr_c  = b_mem_addr;
                    if (mem_ready) begin
                        b_ready_c = 1'b1;
                        state_d   = MEM_IDLE;
                        rr_d      = SIDE_A;
                    end
                end
            end
            default: begin
                state_d = MEM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= MEM_IDLE;
            rr_q      <= SIDE_A;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            if (a_ready_c) begin
                a_rdata_q <= mem_rdata;
            end
            if (b_ready_c) begin
                b_rdata_q <= mem_rdata;
            end
        end
    end

    // Gating with reset_n drops an in-flight request the instant reset asserts.
    always_comb begin
        mem_valid   = reset_n & mem_valid_c;
        mem_addr    = reset_n ? mem_addr_c : '0;
        a_mem_ready = reset_n & a_ready_c;
        b_mem_ready = reset_n & b_ready_c;
        a_mem_rdata = a_mem_ready ? mem_rdata : a_rdata_q;
        b_mem_rdata = b_mem_ready ? mem_rdata : b_rdata_q;
    end

    pcm_mux_owner u_mux_owner (
        .clk            (clk),
        .reset_n        (reset_n),
        .a_mux_needed   (a_mux_needed),
        .a_mux_bus      (a_mux_bus),
        .b_mux_needed   (b_mux_needed),
        .b_mux_bus      (b_mux_bus),
        .stat_clear     (stat_clear),
        .mux_bus        (mux_bus),
        .conflict_count (conflict_count)
    );

    always_comb begin
        mux_sel   = mux_bus[MUX_SEL_LSB +: MUX_SEL_W];
        mux_oe_n  = mux_bus[MUX_OE_N_BIT];
        ym_io_out = mux_bus[YM_IO_OUT_LSB +: YM_IO_OUT_W];
        ym_io_en  = mux_bus[YM_IO_EN_BIT];
        pcm_load  = mux_bus[PCM_LOAD_BIT];
    end

endmodule

// File: tb/tb_adpcm_pcm_arbiter.sv
// Scenario-per-task bench for adpcm_pcm_arbiter; read completions are checked
// against a scoreboard of expected {side, data} pushed when each read is served.
module tb_adpcm_pcm_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rst_bp_n = 1'b0;
    logic        a_mem_valid = 1'b0, b_mem_valid = 1'b0;
    logic [23:0] a_mem_addr = '0, b_mem_addr = '0;
    logic        mem_ready = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic        a_mux_needed = 1'b0, b_mux_needed = 1'b0;
    logic [9:0]  a_mux_bus = '0, b_mux_bus = '0;
    logic        stat_clear = 1'b0;

    logic        a_mem_ready, b_mem_ready, mem_valid;
    logic [7:0]  a_mem_rdata, b_mem_rdata;
    logic [23:0] mem_addr;
    logic [2:0]  mux_sel;
    logic        mux_oe_n, ym_io_en, pcm_load;
    logic [3:0]  ym_io_out;
    logic [7:0]  conflict_count;
    logic [9:0]  pins;

    logic        bp_a_ready, bp_b_ready, bp_mem_valid;
    logic [7:0]  bp_a_rdata, bp_b_rdata;
    logic [23:0] bp_mem_addr;
    logic [2:0]  bp_mux_sel;
    logic        bp_mux_oe_n, bp_ym_io_en, bp_pcm_load;
    logic [3:0]  bp_ym_io_out;
    logic [7:0]  bp_conflict_count;

    typedef struct {
        logic       side_b;
        logic [7:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic [7:0] mon_data;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    assign pins = {pcm_load, ym_io_en, ym_io_out, mux_oe_n, mux_sel};

    adpcm_pcm_arbiter #(.ROUND_ROBIN(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_mem_valid(a_mem_valid), .a_mem_addr(a_mem_addr),
        .a_mem_ready(a_mem_ready), .a_mem_rdata(a_mem_rdata),
        .b_mem_valid(b_mem_valid), .b_mem_addr(b_mem_addr),
        .b_mem_ready(b_mem_ready), .b_mem_rdata(b_mem_rdata),
        .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .a_mux_needed(a_mux_needed), .a_mux_bus(a_mux_bus),
        .b_mux_needed(b_mux_needed), .b_mux_bus(b_mux_bus),
        .mux_sel(mux_sel), .mux_oe_n(mux_oe_n), .ym_io_out(ym_io_out),
        .ym_io_en(ym_io_en), .pcm_load(pcm_load),
        .conflict_count(conflict_count), .stat_clear(stat_clear)
    );

    adpcm_pcm_arbiter #(.ROUND_ROBIN(0)) dut_bp (
        .clk(clk), .reset_n(rst_bp_n),
        .a_mem_valid(a_mem_valid), .a_mem_addr(a_mem_addr),
        .a_mem_ready(bp_a_ready), .a_mem_rdata(bp_a_rdata),
        .b_mem_valid(b_mem_valid), .b_mem_addr(b_mem_addr),
        .b_mem_ready(bp_b_ready), .b_mem_rdata(bp_b_rdata),
        .mem_valid(bp_mem_valid), .mem_addr(bp_mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .a_mux_needed(a_mux_needed), .a_mux_bus(a_mux_bus),
        .b_mux_needed(b_mux_needed), .b_mux_bus(b_mux_bus),
        .mux_sel(bp_mux_sel), .mux_oe_n(bp_mux_oe_n), .ym_io_out(bp_ym_io_out),
        .ym_io_en(bp_ym_io_en), .pcm_load(bp_pcm_load),
        .conflict_count(bp_conflict_count), .stat_clear(stat_clear)
    );

    // Every completion pulse from the round-robin instance consumes one scoreboard entry.
    always @(negedge clk) begin
        if (a_mem_ready || b_mem_ready) begin
            n_checks++;
            if (a_mem_ready && b_mem_ready) begin
                n_fail++;
                $display("[TB] FAIL sb_both_ready: a_ready=%b b_ready=%b, expected only one", a_mem_ready, b_mem_ready);
            end else if (sb_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL sb_unexpected: ready on side_b=%b with empty scoreboard", b_mem_ready);
            end else begin
                mon_e = sb_q.pop_front();
                mon_data = b_mem_ready ? b_mem_rdata : a_mem_rdata;
                if (b_mem_ready !== mon_e.side_b || mon_data !== mon_e.data) begin
                    n_fail++;
                    $display("[TB] FAIL sb_completion: got side_b=%b data=%h, expected side_b=%b data=%h",
                             b_mem_ready, mon_data, mon_e.side_b, mon_e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a_mem_valid = 1'b0; b_mem_valid = 1'b0;
        a_mem_addr = '0; b_mem_addr = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        a_mux_needed = 1'b0; b_mux_needed = 1'b0;
        a_mux_bus = '0; b_mux_bus = '0;
        stat_clear = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        a_mem_valid = 1'b1; a_mem_addr = 24'h00F00D;
        a_mux_needed = 1'b1; a_mux_bus = 10'h3FF;
        #2;
        n_checks++;
        if (mem_valid !== 1'b0 || mem_addr !== 24'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_mem_idle: got valid=%b addr=%h, expected 0/000000", mem_valid, mem_addr);
        end
        n_checks++;
        if (pins !== 10'h008) begin
            n_fail++;
            $display("[TB] FAIL reset_pins_idle: got %h, expected 008", pins);
        end
        clear_inputs();
        step();
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (a_mem_ready !== 1'b0 || b_mem_ready !== 1'b0 || a_mem_rdata !== 8'h00 ||
            b_mem_rdata !== 8'h00 || conflict_count !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got ar=%b br=%b ad=%h bd=%h cnt=%h, expected all 0",
                     a_mem_ready, b_mem_ready, a_mem_rdata, b_mem_rdata, conflict_count);
        end
    endtask

    task automatic test_a_only();
        do_reset();
        a_mem_valid = 1'b1; a_mem_addr = 24'h012345;
        #1;
        n_checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 24'h012345) begin
            n_fail++;
            $display("[TB] FAIL a_only_zero_latency: got valid=%b addr=%h, expected 1/012345", mem_valid, mem_addr);
        end
        step();
        n_checks++;
        if (mem_addr !== 24'h012345 || a_mem_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL a_only_grant_hold: got addr=%h ready=%b, expected 012345/0", mem_addr, a_mem_ready);
        end
        step();
        step();
        sb_q.push_back('{side_b: 1'b0, data: 8'hA7});
        mem_ready = 1'b1; mem_rdata = 8'hA7;
        #1;
        n_checks++;
        if (a_mem_ready !== 1'b1 || a_mem_rdata !== 8'hA7 || b_mem_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL a_only_ready: got ar=%b ad=%h br=%b, expected 1/a7/0", a_mem_ready, a_mem_rdata, b_mem_ready);
        end
        step();
        a_mem_valid = 1'b0; mem_ready = 1'b0; mem_rdata = 8'h00;
        #1;
        n_checks++;
        if (a_mem_ready !== 1'b0 || a_mem_rdata !== 8'hA7 || mem_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL a_only_rdata_hold: got ar=%b ad=%h mv=%b, expected 0/a7/0", a_mem_ready, a_mem_rdata, mem_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        a_mem_valid = 1'b1; a_mem_addr = 24'h00AAAA;
        b_mem_valid = 1'b1; b_mem_addr = 24'h0BBBBB;
        #1;
        n_checks++;
        if (mem_addr !== 24'h00AAAA) begin
            n_fail++;
            $display("[TB] FAIL rr_first_a: got addr=%h, expected 00aaaa", mem_addr);
        end
        step();
        sb_q.push_back('{side_b: 1'b0, data: 8'h11});
        mem_ready = 1'b1; mem_rdata = 8'h11;
        #1;
        n_checks++;
        if (mem_addr !== 24'h00AAAA || b_mem_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rr_no_same_cycle_switch: got addr=%h br=%b, expected 00aaaa/0", mem_addr, b_mem_ready);
        end
        step();
        mem_ready = 1'b0; a_mem_addr = 24'h00A2A2;
        #1;
        n_checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 24'h0BBBBB) begin
            n_fail++;
            $display("[TB] FAIL rr_repeat_b_first: got valid=%b addr=%h, expected 1/0bbbbb", mem_valid, mem_addr);
        end
        step();
        sb_q.push_back('{side_b: 1'b1, data: 8'h22});
        mem_ready = 1'b1; mem_rdata = 8'h22;
        #1;
        n_checks++;
        if (mem_addr !== 24'h0BBBBB || a_mem_ready !== 1'b0 || a_mem_rdata !== 8'h11) begin
            n_fail++;
            $display("[TB] FAIL rr_b_served: got addr=%h ar=%b ad=%h, expected 0bbbbb/0/11", mem_addr, a_mem_ready, a_mem_rdata);
        end
        step();
        mem_ready = 1'b0; b_mem_valid = 1'b0;
        #1;
        n_checks++;
        if (mem_addr !== 24'h00A2A2) begin
            n_fail++;
            $display("[TB] FAIL rr_back_to_a: got addr=%h, expected 00a2a2", mem_addr);
        end
        step();
        sb_q.push_back('{side_b: 1'b0, data: 8'h33});
        mem_ready = 1'b1; mem_rdata = 8'h33;
        step();
        mem_ready = 1'b0; a_mem_valid = 1'b0;
        #1;
        n_checks++;
        if (mem_valid !== 1'b0 || b_mem_rdata !== 8'h22) begin
            n_fail++;
            $display("[TB] FAIL rr_idle_after: got valid=%b bd=%h, expected 0/22", mem_valid, b_mem_rdata);
        end
    endtask

    task automatic test_protocol_error();
        do_reset();
        b_mem_valid = 1'b1; b_mem_addr = 24'h0E0E0E;
        step();
        b_mem_valid = 1'b0; mem_ready = 1'b1; mem_rdata = 8'h5C;
        #1;
        n_checks++;
        if (mem_valid !== 1'b0 || b_mem_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL proto_drop: got valid=%b br=%b, expected 0/0", mem_valid, b_mem_ready);
        end
        step();
        mem_ready = 1'b0;
        a_mem_valid = 1'b1; a_mem_addr = 24'h0A0A0A;
        #1;
        n_checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 24'h0A0A0A) begin
            n_fail++;
            $display("[TB] FAIL proto_back_idle: got valid=%b addr=%h, expected 1/0a0a0a", mem_valid, mem_addr);
        end
        step();
        sb_q.push_back('{side_b: 1'b0, data: 8'h77});
        mem_ready = 1'b1; mem_rdata = 8'h77;
        step();
        mem_ready = 1'b0; a_mem_valid = 1'b0;
    endtask

    task automatic test_fixed_priority();
        reset_n = 1'b0;
        clear_inputs();
        step();
        a_mem_valid = 1'b1; a_mem_addr = 24'h0A0001;
        b_mem_valid = 1'b1; b_mem_addr = 24'h0B0001;
        rst_bp_n = 1'b1;
        #1;
        n_checks++;
        if (bp_mem_valid !== 1'b1 || bp_mem_addr !== 24'h0B0001) begin
            n_fail++;
            $display("[TB] FAIL bprio_first: got valid=%b addr=%h, expected 1/0b0001", bp_mem_valid, bp_mem_addr);
        end
        step();
        mem_ready = 1'b1; mem_rdata = 8'h44;
        #1;
        n_checks++;
        if (bp_b_ready !== 1'b1 || bp_b_rdata !== 8'h44 || bp_a_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL bprio_ready: got br=%b bd=%h ar=%b, expected 1/44/0", bp_b_ready, bp_b_rdata, bp_a_ready);
        end
        step();
        mem_ready = 1'b0; b_mem_addr = 24'h0B0002;
        #1;
        n_checks++;
        if (bp_mem_addr !== 24'h0B0002) begin
            n_fail++;
            $display("[TB] FAIL bprio_second: got addr=%h, expected 0b0002", bp_mem_addr);
        end
        step();
        rst_bp_n = 1'b0;
        clear_inputs();
    endtask

    task automatic test_mux_conflict();
        do_reset();
        b_mux_needed = 1'b1; b_mux_bus = 10'h2B5;
        a_mux_needed = 1'b1; a_mux_bus = 10'h14A;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (pins !== 10'h2B5) begin
                n_fail++;
                $display("[TB] FAIL mux_follow_b[%0d]: got %h, expected 2b5", i, pins);
            end
            step();
        end
        a_mux_needed = 1'b0;
        #1;
        n_checks++;
        if (conflict_count !== 8'd3 || pins !== 10'h2B5) begin
            n_fail++;
            $display("[TB] FAIL mux_conflict_3: got cnt=%0d pins=%h, expected 3/2b5", conflict_count, pins);
        end
        step();
        a_mux_needed = 1'b1;
        repeat (260) step();
        n_checks++;
        if (conflict_count !== 8'd255) begin
            n_fail++;
            $display("[TB] FAIL mux_saturate: got %0d, expected 255", conflict_count);
        end
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0; a_mux_needed = 1'b0;
        step();
        n_checks++;
        if (conflict_count !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL mux_stat_clear: got %0d, expected 0", conflict_count);
        end
        b_mux_needed = 1'b0;
    endtask

    task automatic test_mux_handover();
        do_reset();
        a_mux_needed = 1'b1; a_mux_bus = 10'h0F1;
        #1;
        n_checks++;
        if (pins !== 10'h0F1) begin
            n_fail++;
            $display("[TB] FAIL mux_a_alone: got %h, expected 0f1", pins);
        end
        step();
        b_mux_needed = 1'b1; b_mux_bus = 10'h30E;
        #1;
        n_checks++;
        if (pins !== 10'h0F1) begin
            n_fail++;
            $display("[TB] FAIL mux_owner_keeps: got %h, expected 0f1", pins);
        end
        step();
        a_mux_needed = 1'b0;
        #1;
        n_checks++;
        if (pins !== 10'h30E || conflict_count !== 8'd1) begin
            n_fail++;
            $display("[TB] FAIL mux_handover: got pins=%h cnt=%0d, expected 30e/1", pins, conflict_count);
        end
        step();
        b_mux_needed = 1'b0;
        #1;
        n_checks++;
        if (pins !== 10'h008) begin
            n_fail++;
            $display("[TB] FAIL mux_release_idle: got %h, expected 008", pins);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        b_mem_valid = 1'b1; b_mem_addr = 24'h0C0C0C;
        b_mux_needed = 1'b1; b_mux_bus = 10'h155;
        step();
        #1;
        n_checks++;
        if (mem_valid !== 1'b1 || pins !== 10'h155) begin
            n_fail++;
            $display("[TB] FAIL rmid_pre: got valid=%b pins=%h, expected 1/155", mem_valid, pins);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (mem_valid !== 1'b0 || mem_addr !== 24'h0 || pins !== 10'h008) begin
            n_fail++;
            $display("[TB] FAIL rmid_async: got valid=%b addr=%h pins=%h, expected 0/000000/008", mem_valid, mem_addr, pins);
        end
        mem_ready = 1'b1; mem_rdata = 8'h99;
        #1;
        n_checks++;
        if (b_mem_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rmid_no_ready: got %b, expected 0", b_mem_ready);
        end
        mem_ready = 1'b0;
        step();
        step();
        b_mem_addr = 24'h0D0D0D;
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 24'h0D0D0D) begin
            n_fail++;
            $display("[TB] FAIL rmid_post_grant: got valid=%b addr=%h, expected 1/0d0d0d", mem_valid, mem_addr);
        end
        step();
        sb_q.push_back('{side_b: 1'b1, data: 8'h66});
        mem_ready = 1'b1; mem_rdata = 8'h66;
        step();
        mem_ready = 1'b0; b_mem_valid = 1'b0; b_mux_needed = 1'b0;
        step();
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_a_only();
        test_round_robin();
        test_protocol_error();
        test_fixed_priority();
        test_mux_conflict();
        test_mux_handover();
        test_reset_mid();
        step();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
